// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizes for the mem_ctrl asynchronous-RAM front-end.
package mem_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  // Wait counter covers ACCESS_CYCLES-1 for ACCESS_CYCLES in 1..15.
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } mem_ctrl_state_e;

endpackage

// File: rtl/mem_ctrl.sv
// Request/response front-end for a 16-bit asynchronous RAM. Each request runs
// SETUP (address/data settle, strobes low), ACCESS (strobes high for
// ACCESS_CYCLES), HOLD (strobes low, address still held), then RESP.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. The producer holds valid and its payload stable until that edge; ready
// never depends combinationally on valid. All outputs come straight from flops.
// The current FSM state is visible as state_q for observation.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_i,
  input  logic [DATA_W-1:0] ram_data_o,
  output logic              ram_operation_flag,
  output logic              ram_read,
  output logic              ram_write
);

  mem_ctrl_state_e   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_i_q, ram_data_i_d;
  logic              ram_op_q, ram_op_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    ram_address_d = ram_address_q;
    ram_data_i_d  = ram_data_i_q;
    ram_op_d      = ram_op_q;
    ram_rd_d      = ram_rd_q;
    ram_wr_d      = ram_wr_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          // Request fields are sampled only here; the address/data flops
          // double as the request latch so the RAM sees them during SETUP.
          write_d       = req_write;
          ram_address_d = req_addr;
          ram_data_i_d  = req_write ? req_wdata : '0;
          rsp_rdata_d   = '0;
          req_ready_d   = 1'b0;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        cnt_d    = CNT_W'(ACCESS_CYCLES - 1);
        ram_op_d = 1'b1;
        ram_rd_d = ~write_q;
        ram_wr_d = write_q;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Last access cycle: read data is valid now, strobes fall next.
          ram_op_d = 1'b0;
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          if (!write_q) rsp_rdata_d = ram_data_o;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = write_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = '0;
          req_ready_d   = 1'b1;
          ram_address_d = '0;
          ram_data_i_d  = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        ram_op_d    = 1'b0;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      ram_address_q <= '0;
      ram_data_i_q  <= '0;
      ram_op_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_wr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      ram_address_q <= ram_address_d;
      ram_data_i_q  <= ram_data_i_d;
      ram_op_q      <= ram_op_d;
      ram_rd_q      <= ram_rd_d;
      ram_wr_q      <= ram_wr_d;
    end
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_write          = rsp_write_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign ram_address        = ram_address_q;
  assign ram_data_i         = ram_data_i_q;
  assign ram_operation_flag = ram_op_q;
  assign ram_read           = ram_rd_q;
  assign ram_write          = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two controllers (ACCESS_CYCLES 1 and 3), each in front of
// a behavioural 64K x 16 asynchronous RAM. One controller at a time carries
// traffic (selected by sel); expected responses come from a bench-side memory
// model and are queued at acceptance, then popped when the response is taken.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_write;
  logic [1:0][15:0] req_addr, req_wdata;
  logic [1:0]       rsp_valid, rsp_ready, rsp_write;
  logic [1:0][15:0] rsp_rdata, ram_address, ram_data_i, ram_data_o;
  logic [1:0]       ram_op, ram_rd, ram_wr;

  mem_ctrl #(.ACCESS_CYCLES(1)) u_dut_ac1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
    .rsp_rdata(rsp_rdata[0]),
    .ram_address(ram_address[0]), .ram_data_i(ram_data_i[0]), .ram_data_o(ram_data_o[0]),
    .ram_operation_flag(ram_op[0]), .ram_read(ram_rd[0]), .ram_write(ram_wr[0])
  );

  mem_ctrl #(.ACCESS_CYCLES(3)) u_dut_ac3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
    .rsp_rdata(rsp_rdata[1]),
    .ram_address(ram_address[1]), .ram_data_i(ram_data_i[1]), .ram_data_o(ram_data_o[1]),
    .ram_operation_flag(ram_op[1]), .ram_read(ram_rd[1]), .ram_write(ram_wr[1])
  );

  // Behavioural asynchronous RAMs: combinational read, write while strobed.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    bit [15:0] mem [0:65535];
    assign ram_data_o[g] = mem[ram_address[g]];
    always @(posedge clk) if (ram_op[g] && ram_wr[g]) mem[ram_address[g]] <= ram_data_i[g];
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic sel    = 1'b0;
  int ac       = 1;

  logic [16:0] exp_q[$];   // {write, rdata}
  int          acc_q[$];   // acceptance edge index per request
  logic [15:0] model [logic [15:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [1:0][15:0] prev_addr = '0;
  logic prev_valid = 1'b0;
  int   op_run = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("rd_wr_overlap", 32'(ram_rd[i] & ram_wr[i]), 32'd0);
      if (ram_address[i] != prev_addr[i]) chk("op_on_addr_change", 32'(ram_op[i]), 32'd0);
      prev_addr[i] = ram_address[i];
    end
    if (!rst_n) begin
      op_run     = 0;
      prev_valid = 1'b0;
    end else begin
      if (ram_op[sel]) begin
        op_run++;
        chk("one_strobe", 32'(ram_rd[sel] ^ ram_wr[sel]), 32'd1);
      end else if (op_run != 0) begin
        chk("op_len", op_run, ac);
        op_run = 0;
      end
      // Acceptance at edge E0 -> rsp_valid visible after edge E0+ACCESS_CYCLES+2,
      // i.e. during cycle E0+ACCESS_CYCLES+3.
      if (rsp_valid[sel] && !prev_valid && acc_q.size() != 0)
        chk("latency", cyc - acc_q.pop_front(), ac + 2);
      if (rsp_valid[sel] && rsp_ready[sel]) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("rsp_write", 32'(rsp_write[sel]), 32'(e[16]));
          chk("rsp_rdata", 32'(rsp_rdata[sel]), 32'(e[15:0]));
        end
      end
      prev_valid = rsp_valid[sel];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic use_dut(input logic s);
    sel = s;
    ac  = s ? 3 : 1;
  endtask

  task automatic send(input logic wr, input logic [15:0] a, input logic [15:0] d,
                      input bit keep, output int acc);
    bit ok = 1'b0;
    acc = -1;
    @(posedge clk); #1;
    req_valid[sel] = 1'b1;
    req_write[sel] = wr;
    req_addr[sel]  = a;
    req_wdata[sel] = d;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[sel]) begin
        @(posedge clk); #1;
        ok  = 1'b1;
        acc = cyc;
      end
    end
    chk("req_accept", 32'(ok), 32'd1);
    if (ok) begin
      if (wr) begin
        model[a] = d;
        exp_q.push_back({1'b1, 16'h0000});
      end else begin
        exp_q.push_back({1'b0, model.exists(a) ? model[a] : 16'h0000});
      end
      acc_q.push_back(acc);
    end
    if (!keep) req_valid[sel] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_outs(input int i);
    chk("rst_ctrl", 32'({req_ready[i], rsp_valid[i], rsp_write[i], ram_op[i], ram_rd[i], ram_wr[i]}),
        32'b100000);
    chk("rst_rdata", 32'(rsp_rdata[i]), 32'd0);
    chk("rst_addr",  32'(ram_address[i]), 32'd0);
    chk("rst_wdata", 32'(ram_data_i[i]), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int a0, a1, a2;
    bit seen;
    logic [15:0] ra, rd;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 2'b11;
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_reset_outs(0);
    check_reset_outs(1);
    #20 rst_n = 1'b1;

    // ACCESS_CYCLES=1: directed write/read then random pairs.
    use_dut(1'b0);
    send(1'b1, 16'h00A5, 16'h1234, 1'b0, a0);
    send(1'b0, 16'h00A5, 16'h0000, 1'b0, a0);
    drain();
    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom_range(0, 65535));
      rd = 16'($urandom_range(0, 65535));
      send(1'b1, ra, rd, 1'b0, a0);
      send(1'b0, ra, 16'h0000, 1'b0, a0);
    end
    drain();

    // ACCESS_CYCLES=3 at the top address with all-ones-style data.
    use_dut(1'b1);
    send(1'b1, 16'hFFFF, 16'hBEEF, 1'b0, a0);
    send(1'b0, 16'hFFFF, 16'h0000, 1'b0, a0);
    drain();

    // Backpressure: response held for 5 cycles.
    @(posedge clk); #1 rsp_ready[1] = 1'b0;
    send(1'b0, 16'hFFFF, 16'h0000, 1'b0, a0);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = rsp_valid[1];
    end
    chk("bp_rsp_seen", 32'(seen), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid[1]), 32'd1);
      chk("bp_rdata", 32'(rsp_rdata[1]), 32'hBEEF);
      chk("bp_req_ready", 32'(req_ready[1]), 32'd0);
    end
    @(posedge clk); #1 rsp_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_req_ready_back", 32'(req_ready[1]), 32'd1);
    chk("bp_valid_drop", 32'(rsp_valid[1]), 32'd0);
    chk("bp_state_idle", 32'(u_dut_ac3.state_q), 32'(mem_ctrl_pkg::IDLE));
    drain();

    // Back-to-back writes with req_valid held, then readback, on both DUTs.
    for (int s = 0; s < 2; s++) begin
      use_dut(s[0]);
      send(1'b1, 16'h0001, 16'h0001, 1'b1, a0);
      send(1'b1, 16'h0002, 16'h0002, 1'b1, a1);
      send(1'b1, 16'h0003, 16'h0003, 1'b0, a2);
      chk("b2b_spacing1", a1 - a0, ac + 4);
      chk("b2b_spacing2", a2 - a1, ac + 4);
      drain();
      for (int k = 1; k <= 3; k++) send(1'b0, 16'(k), 16'h0000, 1'b0, a0);
      drain();
    end

    // Reset during ACCESS of a write on the ACCESS_CYCLES=3 controller.
    use_dut(1'b1);
    send(1'b1, 16'h0077, 16'h5555, 1'b0, a0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = ram_op[1];
    end
    chk("abort_access_seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({ram_op[1], ram_rd[1], ram_wr[1]}), 32'd0);
    chk("abort_req_ready", 32'(req_ready[1]), 32'd1);
    exp_q.delete();
    acc_q.delete();
    model.delete(16'h0077);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid[1]) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    send(1'b0, 16'hFFFF, 16'h0000, 1'b0, a0);
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Synchronous request/response front-end that sits directly upstream of the 16-bit asynchronous RAM.
- Accepts one read or write request at a time from the CPU/datapath over a valid/ready handshake.
- Sequences the RAM's level-sensitive strobes (OPERATION_FLAG, READ, WRITE) with a setup, access and hold phase.
- Returns read data, or a write completion, over a valid/ready response channel.

Parameters:
- ACCESS_CYCLES, 1, number of cycles OPERATION_FLAG plus READ/WRITE stay asserted; legal range 1..15.
- ADDR_W, 16, address width; must match the RAM.
- DATA_W, 16, word width; must match the RAM.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data, ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_write  out  1  echo of the request type.
- rsp_rdata  out  DATA_W  read data; 0 for write responses.
- ram_address  out  ADDR_W  drives RAM address.
- ram_data_i  out  DATA_W  drives RAM write data.
- ram_data_o  in  DATA_W  RAM read data.
- ram_operation_flag  out  1  drives OPERATION_FLAG.
- ram_read  out  1  drives READ.
- ram_write  out  1  drives WRITE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_write=0; rsp_rdata=0; all ram_* outputs 0.
- Registered outputs: every output is a flop. No combinational path from any input to any output.

FSM states: IDLE, SETUP, ACCESS, HOLD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr, wdata and type; go to SETUP.
- SETUP (1 cycle):
  - ram_address and ram_data_i (writes only) driven from the latch.
  - All strobes 0.
  - Go to ACCESS; load the wait counter with ACCESS_CYCLES-1.
- ACCESS (ACCESS_CYCLES cycles):
  - ram_operation_flag=1, and ram_write=type or ram_read=~type.
  - Address and data are held stable.
  - Counter decrements each cycle; at 0 go to HOLD.
  - Reads: capture ram_data_o into rsp_rdata at the clock edge that ends the last ACCESS cycle.
- HOLD (1 cycle):
  - All strobes 0; address and data still held.
  - This guarantees the RAM write strobe falls before the address changes.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_write=latched type; rsp_rdata stable.
  - On rsp_ready go to IDLE. rsp_valid drops and req_ready rises in the same registered update.
- Leaving RESP: ram_address and ram_data_i return to 0.

Timing and rules:
- Latency: acceptance edge E0 → rsp_valid high in cycle E0+ACCESS_CYCLES+3.
- Minimum request spacing with rsp_ready tied 1: ACCESS_CYCLES+4 cycles.
- Invariant: ram_read&&ram_write never 1 simultaneously. Bench asserts every cycle.
- Invariant: ram_operation_flag is never 1 in the cycle that ram_address changes.
- Backpressure: rsp_ready low holds RESP indefinitely with all response outputs stable. No new request is accepted meanwhile.
- req_valid held across busy cycles: the request is accepted in the first IDLE cycle. Request fields are sampled only at acceptance.
- Address 0xFFFF and data 0xFFFF are handled with no wrap or special case.
- Reset mid-operation: all strobes deassert asynchronously and immediately. The in-flight write may be partial (RAM contents undefined at that address). No response is produced for the aborted request.

Decomposition:
- Package mem_ctrl_pkg:
  - ADDR_W and DATA_W localparams.
  - State enum mem_ctrl_state_e {IDLE, SETUP, ACCESS, HOLD, RESP}.
  - Wait counter width constant (4 bits).
- Single module, no sub-module. The wait counter is inline.
- The integration testbench instantiates mem_ctrl plus the RAM.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 and req_ready=1 immediately, without waiting for a clock edge.
- Write then read, ACCESS_CYCLES=1: write 0x1234 to 0x00A5, then read 0x00A5.
  - Strobe sequence is SETUP(0), ACCESS(op=1, write=1), HOLD(0).
  - Read response rsp_rdata=0x1234 at E0+4.
- ACCESS_CYCLES=3: write 0xBEEF to 0xFFFF, then read it back → ram_read high exactly 3 cycles, rsp_rdata=0xBEEF at E0+6; read/write never overlap.
- Backpressure: rsp_ready=0 for 5 cycles during a read → rsp_valid and rsp_rdata stable; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Back-to-back: req_valid held high with 3 queued writes (0x0001/0x0002/0x0003 to addresses 1,2,3) and rsp_ready=1 → accepted every ACCESS_CYCLES+4 cycles; readback matches.
- Reset during ACCESS of a write: rst_n low → strobes 0 asynchronously; after release, rsp_valid stays 0 and the next read request completes normally.
